// File: rtl/npu_rf_pkg.sv
// Shared definitions for the NPU register-file write path.
// Provides default register-file geometry, the address/data typedefs and
// the writeback request record. Contains no ports.
package npu_rf_pkg;

    localparam int unsigned RF_NUM_SRC    = 4;
    localparam int unsigned RF_NUM_REGS   = 32;
    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = $clog2(RF_NUM_REGS);

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requester found at or after the priority pointer,
// wrapping modulo N.
// Ports:
//   req_i  N-bit request vector
//   ptr_i  index of the highest-priority requester
//   gnt_o  one-hot grant (all zero when there is no request)
//   idx_o  index of the granted requester (0 when there is no grant)
//   any_o  a grant was issued
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    int unsigned sum;
    logic [PW-1:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = 0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // Wrap by subtraction so non-power-of-two N never indexes past N-1.
            sum = int'(ptr_i) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            pos = PW'(sum);
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writer-side front end for the NPU register file.
// Merges writeback requests from NUM_SRC producers into the single regfile
// write port (one commit per cycle, round-robin), and tracks a pending-write
// bitmap that issue logic queries for RAW hazards.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   src_valid/ready/addr/data  per-producer writeback handshake
//   alloc_en, alloc_addr       issue stage reserves a destination register
//   wr_en, wr_addr, wr_data    registered regfile write port
//   q_addr1/2, q_busy1/2       combinational hazard queries of the bitmap
//   alloc_err                  one-cycle pulse: alloc to an already-pending register
module regfile_wb_arbiter
    import npu_rf_pkg::*;
#(
    parameter int unsigned NUM_SRC    = RF_NUM_SRC,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned NUM_REGS   = RF_NUM_REGS,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_SRC-1:0]                 src_valid,
    output logic [NUM_SRC-1:0]                 src_ready,
    input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] src_addr,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data,
    input  logic                               alloc_en,
    input  logic [ADDR_WIDTH-1:0]              alloc_addr,
    output logic                               wr_en,
    output logic [ADDR_WIDTH-1:0]              wr_addr,
    output logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [ADDR_WIDTH-1:0]              q_addr1,
    output logic                               q_busy1,
    input  logic [ADDR_WIDTH-1:0]              q_addr2,
    output logic                               q_busy2,
    output logic                               alloc_err
);

    localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PW-1:0]         ptr_q, ptr_d;
    logic [NUM_SRC-1:0]    gnt;
    logic [PW-1:0]         gnt_idx;
    logic                  gnt_any;

    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  alloc_err_q, alloc_err_d;

    rr_arbiter #(
        .N  (NUM_SRC),
        .PW (PW)
    ) u_arb (
        .req_i (src_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // A grant only exists for a valid source, so every grant is a handshake.
    assign src_ready = gnt;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == PW'(NUM_SRC - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Clear (commit) is applied before set (alloc) so a same-register
    // collision leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_q) begin
            pending_d[wr_addr_q] = 1'b0;
        end
        if (alloc_en) begin
            pending_d[alloc_addr] = 1'b1;
        end
    end

    assign alloc_err_d = alloc_en && pending_q[alloc_addr] &&
                         !(wr_en_q && (wr_addr_q == alloc_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            pending_q   <= '0;
            alloc_err_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            wr_en_q     <= gnt_any;
            pending_q   <= pending_d;
            alloc_err_q <= alloc_err_d;
            if (gnt_any) begin
                wr_addr_q <= src_addr[gnt_idx];
                wr_data_q <= src_data[gnt_idx];
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign alloc_err = alloc_err_q;
    assign q_busy1   = pending_q[q_addr1];
    assign q_busy2   = pending_q[q_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import npu_rf_pkg::*;

    localparam int NS = 4;
    localparam int NR = 32;

    logic                              clk = 1'b0;
    logic                              rst;
    logic [NS-1:0]                     src_valid;
    logic [NS-1:0]                     src_ready;
    logic [NS-1:0][RF_ADDR_WIDTH-1:0]  src_addr;
    logic [NS-1:0][RF_DATA_WIDTH-1:0]  src_data;
    logic                              alloc_en;
    rf_addr_t                          alloc_addr;
    logic                              wr_en;
    rf_addr_t                          wr_addr;
    rf_data_t                          wr_data;
    rf_addr_t                          q_addr1, q_addr2;
    logic                              q_busy1, q_busy2;
    logic                              alloc_err;

    regfile_wb_arbiter #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (RF_DATA_WIDTH),
        .NUM_REGS   (NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .q_addr1    (q_addr1),
        .q_busy1    (q_busy1),
        .q_addr2    (q_addr2),
        .q_busy2    (q_busy2),
        .alloc_err  (alloc_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int       m_ptr;
    bit       m_pend [NR];
    bit       m_wr_en;
    rf_addr_t m_wr_addr;
    rf_data_t m_wr_data;
    bit       m_err;
    int       m_g;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner is the valid source with the smallest forward distance from the pointer.
    function automatic int pick(input logic [NS-1:0] v, input int ptr);
        int best  = -1;
        int bestd = NS;
        for (int i = 0; i < NS; i++) begin
            if (v[i]) begin
                int d = (i - ptr + NS) % NS;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_ptr     = 0;
        m_wr_en   = 0;
        m_wr_addr = '0;
        m_wr_data = '0;
        m_err     = 0;
        for (int a = 0; a < NR; a++) m_pend[a] = 0;
    endtask

    // Called just after a rising edge with inputs applied; returns just after the next edge.
    task automatic step();
        bit            n_en;
        rf_addr_t      n_addr;
        rf_data_t      n_data;
        bit            n_err;
        logic [NS-1:0] exp_rdy;
        #1;
        m_g = pick(src_valid, m_ptr);
        exp_rdy = '0;
        if (m_g >= 0) exp_rdy[m_g] = 1'b1;
        chk("src_ready", 64'(src_ready), 64'(exp_rdy));
        chk("q_busy1", 64'(q_busy1), 64'(m_pend[q_addr1]));
        chk("q_busy2", 64'(q_busy2), 64'(m_pend[q_addr2]));

        n_en   = (m_g >= 0);
        n_addr = m_wr_addr;
        n_data = m_wr_data;
        if (n_en) begin
            n_addr = src_addr[m_g];
            n_data = src_data[m_g];
            m_ptr  = (m_g + 1) % NS;
        end
        n_err = alloc_en && m_pend[alloc_addr] && !(m_wr_en && (m_wr_addr == alloc_addr));
        if (m_wr_en) m_pend[m_wr_addr] = 0;
        if (alloc_en) m_pend[alloc_addr] = 1;
        m_wr_en   = n_en;
        m_wr_addr = n_addr;
        m_wr_data = n_data;
        m_err     = n_err;

        @(posedge clk);
        #1;
        chk("wr_en", 64'(wr_en), 64'(m_wr_en));
        chk("wr_addr", 64'(wr_addr), 64'(m_wr_addr));
        chk("wr_data", 64'(wr_data), 64'(m_wr_data));
        chk("alloc_err", 64'(alloc_err), 64'(m_err));
        if (m_g >= 0) src_valid[m_g] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_alloc_err", 64'(alloc_err), 64'(0));
        for (int a = 0; a < NR; a++) begin
            q_addr1 = rf_addr_t'(a);
            q_addr2 = rf_addr_t'(NR - 1 - a);
            #1;
            chk("rst_q_busy1", 64'(q_busy1), 64'(0));
            chk("rst_q_busy2", 64'(q_busy2), 64'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_src(input int i, input rf_addr_t a, input rf_data_t d);
        src_valid[i] = 1'b1;
        src_addr[i]  = a;
        src_data[i]  = d;
    endtask

    initial begin
        rst        = 1'b1;
        src_valid  = '0;
        src_addr   = '0;
        src_data   = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        q_addr1    = '0;
        q_addr2    = '0;
        do_reset();

        // Fairness: all four held valid for eight cycles
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NS; i++)
                if (!src_valid[i]) load_src(i, rf_addr_t'($urandom_range(0, NR - 1)), $urandom);
            #1;
            chk("fair_gnt", 64'(src_ready), 64'(1 << (k % NS)));
            step();
            chk("fair_wr_en", 64'(wr_en), 64'(1));
        end
        src_valid = '0;

        // Single source: src2 -> addr 5
        load_src(2, rf_addr_t'(5), 32'hDEAD_BEEF);
        #1;
        chk("single_rdy", 64'(src_ready), 64'(4'b0100));
        step();
        chk("single_wr_en", 64'(wr_en), 64'(1));
        chk("single_wr_addr", 64'(wr_addr), 64'(5));
        chk("single_wr_data", 64'(wr_data), 64'(32'hDEAD_BEEF));
        step();
        chk("single_idle", 64'(wr_en), 64'(0));

        // Hazard: alloc 7, src1 writes 7
        alloc_en = 1'b1; alloc_addr = rf_addr_t'(7); q_addr1 = rf_addr_t'(7);
        step();
        alloc_en = 1'b0;
        #1;
        chk("haz_busy_set", 64'(q_busy1), 64'(1));
        load_src(1, rf_addr_t'(7), 32'h1234_5678);
        step();
        chk("haz_busy_wr", 64'(q_busy1), 64'(1));
        chk("haz_wr_en", 64'(wr_en), 64'(1));
        step();
        chk("haz_busy_clr", 64'(q_busy1), 64'(0));

        // Set wins: alloc 3 in the cycle commit of 3 happens
        alloc_en = 1'b1; alloc_addr = rf_addr_t'(3); q_addr1 = rf_addr_t'(3);
        step();
        alloc_en = 1'b0;
        load_src(0, rf_addr_t'(3), 32'hCAFE_0003);
        step();
        alloc_en = 1'b1; alloc_addr = rf_addr_t'(3);
        step();
        alloc_en = 1'b0;
        chk("setwin_err", 64'(alloc_err), 64'(0));
        #1;
        chk("setwin_busy", 64'(q_busy1), 64'(1));

        // Double alloc of 9
        alloc_en = 1'b1; alloc_addr = rf_addr_t'(9); q_addr1 = rf_addr_t'(9);
        step();
        step();
        chk("dbl_err_hi", 64'(alloc_err), 64'(1));
        alloc_en = 1'b0;
        step();
        chk("dbl_err_lo", 64'(alloc_err), 64'(0));
        #1;
        chk("dbl_busy", 64'(q_busy1), 64'(1));

        // Reset mid-stream with a commit in flight
        for (int i = 0; i < NS; i++) load_src(i, rf_addr_t'(i + 20), $urandom);
        step();
        do_reset();
        src_valid[0] = 1'b1;
        src_valid[3] = 1'b1;
        #1;
        chk("rst_grant", 64'(src_ready), 64'(4'b0001));
        step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++)
                if (!src_valid[i] && $urandom_range(0, 2) == 0)
                    load_src(i, rf_addr_t'($urandom_range(0, 15)), $urandom);
            alloc_en   = ($urandom_range(0, 3) == 0);
            alloc_addr = rf_addr_t'($urandom_range(0, 15));
            q_addr1    = rf_addr_t'($urandom_range(0, 15));
            q_addr2    = ($urandom_range(0, 1) == 0) ? m_wr_addr : rf_addr_t'($urandom_range(0, NR - 1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
